// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// functs, ALU control codes and datapath select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12,
    JALEX   = 4'd13,
    JREX    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_DATA   = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/aludec.sv
// ALU decoder shared with the single-cycle core: aluop/funct -> alucontrol.
// funct_ok flags a supported R-type funct independent of aluop.
module aludec import mips_ctrl_pkg::*; #(
  parameter int FW = 6
) (
  input  logic [1:0]    aluop,
  input  logic [FW-1:0] funct,
  output logic [2:0]    alucontrol,
  output logic          funct_ok
);

  logic [2:0] fctl;

  // Kept apart from the aluop mux so funct_ok never depends on aluop.
  always_comb begin
    fctl     = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      F_ADD:   fctl = ALU_ADD;
      F_SUB:   fctl = ALU_SUB;
      F_AND:   fctl = ALU_AND;
      F_OR:    fctl = ALU_OR;
      F_SLT:   fctl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_SUB: alucontrol = ALU_SUB;
      default: alucontrol = fctl;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback
// and drives datapath strobes and selects, gated only by mem_ready and zero.
module multicycle_controller import mips_ctrl_pkg::*; #(
  parameter int OPW     = 6,
  parameter int FW      = 6,
  parameter int ACW     = 3,
  parameter bit HAS_JAL = 1'b1,
  parameter bit HAS_BNE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FW-1:0]  funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pcen,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic [1:0]     regdst,
  output logic [1:0]     memtoreg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [ACW-1:0] alucontrol,
  output logic           illegal_op,
  output logic [3:0]     state_o
);

  state_t     state, next, dec_next;
  logic [1:0] aluop;
  logic [2:0] alu_ctl;
  logic       funct_ok, dec_illegal, alu_use;

  aludec #(.FW(FW)) u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_ctl),
    .funct_ok   (funct_ok)
  );

  always_comb begin
    dec_next    = FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW: dec_next = MEMADR;
      OP_RTYPE:
        if (HAS_JAL && funct == F_JR) dec_next = JREX;
        else if (funct_ok)            dec_next = RTYPEEX;
        else                          dec_illegal = 1'b1;
      OP_BEQ:  dec_next = BEQEX;
      OP_BNE:  if (HAS_BNE) dec_next = BNEEX; else dec_illegal = 1'b1;
      OP_ADDI: dec_next = ADDIEX;
      OP_J:    dec_next = JEX;
      OP_JAL:  if (HAS_JAL) dec_next = JALEX; else dec_illegal = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (state)
      FETCH:   next = mem_ready ? DECODE : FETCH;
      DECODE:  next = dec_next;
      MEMADR:  next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next = mem_ready ? MEMWB : MEMRD;
      MEMWR:   next = mem_ready ? FETCH : MEMWR;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= next;

  // Everything decodes to zero while reset is held, even though state is FETCH.
  always_comb begin
    pcen = 1'b0; iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0;
    regdst = RD_RT; memtoreg = M2R_ALUOUT; alusrca = 1'b0; alusrcb = SRCB_B;
    pcsrc = PC_ALURES; aluop = AOP_ADD; alu_use = 1'b0; illegal_op = 1'b0;
    if (reset) begin
      case (state)
        FETCH:   begin alusrcb = SRCB_FOUR; alu_use = 1'b1; irwrite = mem_ready; pcen = mem_ready; end
        DECODE:  begin alusrcb = SRCB_IMMSH; alu_use = 1'b1; illegal_op = dec_illegal; end
        MEMADR:  begin alusrca = 1'b1; alusrcb = SRCB_IMM; alu_use = 1'b1; end
        MEMRD:   iord = 1'b1;
        MEMWB:   begin regwrite = 1'b1; memtoreg = M2R_DATA; end
        MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
        RTYPEEX: begin alusrca = 1'b1; aluop = AOP_FUNCT; alu_use = 1'b1; end
        RTYPEWB: begin regwrite = 1'b1; regdst = RD_RD; end
        BEQEX, BNEEX: begin
          alusrca = 1'b1; aluop = AOP_SUB; alu_use = 1'b1; pcsrc = PC_ALUOUT;
          pcen = (state == BEQEX) ? zero : ~zero;
        end
        ADDIEX:  begin alusrca = 1'b1; alusrcb = SRCB_IMM; alu_use = 1'b1; end
        ADDIWB:  regwrite = 1'b1;
        JEX:     begin pcsrc = PC_JUMP; pcen = 1'b1; end
        JALEX:   begin pcsrc = PC_JUMP; pcen = 1'b1; regwrite = 1'b1; regdst = RD_RA; memtoreg = M2R_PC; end
        JREX:    begin pcsrc = PC_REG; pcen = 1'b1; end
        default: ;
      endcase
    end
  end

  assign alucontrol = alu_use ? ACW'(alu_ctl) : '0;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle plans built from the
// instruction-class rules, replayed against the DUT one cycle at a time.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regwrite;
    logic [1:0] regdst, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      nm;
    logic [5:0] op, fn;
    logic       z, mr;
    outs_t      e;
    int         st;   // -1: encoding not pinned for this cycle
  } rec_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_BEQ = 4, C_BNE = 5,
                 C_ADDI = 6, C_J = 7, C_JAL = 8, C_ILL = 9;

  logic clk = 1'b0, reset;
  logic [5:0] op, funct, op2, funct2;
  logic zero, mem_ready;

  logic pcen, iord, memwrite, irwrite, regwrite, alusrca, illegal_op;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] st;
  logic pcen2, iord2, memwrite2, irwrite2, regwrite2, alusrca2, illegal2;
  logic [1:0] regdst2, memtoreg2, alusrcb2, pcsrc2;
  logic [2:0] alucontrol2;
  logic [3:0] st2;
  outs_t act, act2;

  int checks = 0, failures = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op), .state_o(st)
  );

  multicycle_controller #(.HAS_JAL(1'b0), .HAS_BNE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .op(op2), .funct(funct2), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen2), .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2), .regwrite(regwrite2),
    .regdst(regdst2), .memtoreg(memtoreg2), .alusrca(alusrca2), .alusrcb(alusrcb2),
    .pcsrc(pcsrc2), .alucontrol(alucontrol2), .illegal_op(illegal2), .state_o(st2)
  );

  assign act  = {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal_op};
  assign act2 = {pcen2, iord2, memwrite2, irwrite2, regwrite2, regdst2, memtoreg2, alusrca2,
                 alusrcb2, pcsrc2, alucontrol2, illegal2};

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic int classify(logic [5:0] o, logic [5:0] f);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b000000:
        if (f == 6'b001000) return C_JR;
        else if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return C_R;
        else return C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic outs_t fetch_o(logic mr);
    outs_t o = '0;
    o.alusrcb = 2'b01; o.alucontrol = 3'b010; o.irwrite = mr; o.pcen = mr;
    return o;
  endfunction

  function automatic outs_t decode_o(logic ill);
    outs_t o = '0;
    o.alusrcb = 2'b11; o.alucontrol = 3'b010; o.illegal = ill;
    return o;
  endfunction

  task automatic push(string nm, logic [5:0] o_, logic [5:0] f_, logic z, logic mr, outs_t e, int s);
    rec_t r;
    r.nm = nm; r.op = o_; r.fn = f_; r.z = z; r.mr = mr; r.e = e; r.st = s;
    q.push_back(r);
  endtask

  // fw / mw: cycles of mem_ready=0 before the fetch / data access completes.
  task automatic add_instr(string nm, logic [5:0] iop, logic [5:0] ifn, logic iz, int fw, int mw);
    outs_t o;
    int c = classify(iop, ifn);
    for (int i = 0; i <= fw; i++) push(nm, iop, ifn, iz, i == fw, fetch_o(i == fw), 0);
    push(nm, iop, ifn, iz, 1'b1, decode_o(c == C_ILL), 1);
    o = '0;
    case (c)
      C_LW, C_SW: begin
        o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
        push(nm, iop, ifn, iz, 1'b1, o, 2);
        for (int i = 0; i <= mw; i++) begin
          o = '0; o.iord = 1'b1; o.memwrite = (c == C_SW);
          push(nm, iop, ifn, iz, i == mw, o, (c == C_LW) ? 3 : -1);
        end
        if (c == C_LW) begin
          o = '0; o.regwrite = 1'b1; o.memtoreg = 2'b01;
          push(nm, iop, ifn, iz, 1'b1, o, 4);
        end
      end
      C_R: begin
        o.alusrca = 1'b1; o.alucontrol = alu_of(ifn);
        push(nm, iop, ifn, iz, 1'b1, o, -1);
        o = '0; o.regwrite = 1'b1; o.regdst = 2'b01;
        push(nm, iop, ifn, iz, 1'b1, o, -1);
      end
      C_BEQ, C_BNE: begin
        o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
        o.pcen = (c == C_BEQ) ? iz : ~iz;
        push(nm, iop, ifn, iz, 1'b1, o, -1);
      end
      C_ADDI: begin
        o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
        push(nm, iop, ifn, iz, 1'b1, o, -1);
        o = '0; o.regwrite = 1'b1;
        push(nm, iop, ifn, iz, 1'b1, o, -1);
      end
      C_J:   begin o.pcsrc = 2'b10; o.pcen = 1'b1; push(nm, iop, ifn, iz, 1'b1, o, -1); end
      C_JAL: begin
        o.pcsrc = 2'b10; o.pcen = 1'b1; o.regwrite = 1'b1; o.regdst = 2'b10; o.memtoreg = 2'b10;
        push(nm, iop, ifn, iz, 1'b1, o, -1);
      end
      C_JR:  begin o.pcsrc = 2'b11; o.pcen = 1'b1; push(nm, iop, ifn, iz, 1'b1, o, -1); end
      default: ;
    endcase
  endtask

  task automatic run_q();
    rec_t r;
    int n = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      op = r.op; funct = r.fn; zero = r.z; mem_ready = r.mr;
      @(negedge clk);
      chk($sformatf("%s cyc%0d outs", r.nm, n), act, r.e);
      if (r.st >= 0) chk($sformatf("%s cyc%0d state", r.nm, n), st, r.st);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic dut2_illegal(string nm, logic [5:0] o_, logic [5:0] f_);
    mem_ready = 1'b1; op2 = o_; funct2 = f_;
    do_reset();
    @(negedge clk); chk({nm, " fetch"}, act2, fetch_o(1'b1));
    @(negedge clk); chk({nm, " decode"}, act2, decode_o(1'b1)); chk({nm, " decode state"}, st2, 1);
    @(negedge clk); chk({nm, " back to fetch"}, st2, 0);
  endtask

  initial begin
    int n0, mwc;
    reset = 1'b0; op = 6'b100011; funct = '0; op2 = '0; funct2 = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset outs", act, 0);
      chk("reset state", st, 0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("release irwrite", irwrite, 1); chk("release pcen", pcen, 1); chk("release state", st, 0);
    @(negedge clk); chk("release decode", st, 1);

    // Pin the model against hand-counted CPI before replaying it.
    n0 = q.size(); add_instr("lw", 6'b100011, 6'h00, 1'b0, 0, 0); chk("model lw len", q.size() - n0, 5);
    n0 = q.size(); add_instr("lw_wait", 6'b100011, 6'h00, 1'b0, 0, 2); chk("model lw_wait len", q.size() - n0, 7);
    n0 = q.size(); add_instr("sw_wait", 6'b101011, 6'h00, 1'b0, 0, 3);
    mwc = 0;
    for (int i = n0; i < q.size(); i++) if (q[i].e.memwrite) mwc++;
    chk("model sw memwrite cycles", mwc, 4);
    n0 = q.size(); add_instr("beq_t", 6'b000100, 6'h00, 1'b1, 0, 0); chk("model beq len", q.size() - n0, 3);
    add_instr("beq_nt", 6'b000100, 6'h00, 1'b0, 0, 0);
    add_instr("bne_t",  6'b000101, 6'h00, 1'b0, 0, 0);
    add_instr("bne_nt", 6'b000101, 6'h00, 1'b1, 0, 0);
    add_instr("slt",    6'b000000, 6'b101010, 1'b0, 0, 0);
    add_instr("badfn",  6'b000000, 6'b000111, 1'b0, 0, 0);
    add_instr("add",    6'b000000, 6'b100000, 1'b0, 0, 0);
    add_instr("sub",    6'b000000, 6'b100010, 1'b1, 0, 0);
    add_instr("and",    6'b000000, 6'b100100, 1'b0, 0, 0);
    add_instr("or",     6'b000000, 6'b100101, 1'b0, 0, 0);
    add_instr("jal",    6'b000011, 6'h00, 1'b0, 0, 0);
    add_instr("jr",     6'b000000, 6'b001000, 1'b0, 0, 0);
    add_instr("addi",   6'b001000, 6'h00, 1'b0, 1, 0);
    add_instr("badop",  6'b111111, 6'h00, 1'b0, 0, 0);
    add_instr("sw",     6'b101011, 6'h00, 1'b0, 2, 0);
    add_instr("j",      6'b000010, 6'h00, 1'b0, 0, 0);
    add_instr("lw_end", 6'b100011, 6'h00, 1'b0, 0, 1);
    do_reset();
    run_q();

    // Reset asserted while a store is waiting on memory must drop memwrite at once.
    op = 6'b101011; mem_ready = 1'b1; zero = 1'b0;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("midreset memwrite before", memwrite, 1);
    reset = 1'b0; #1;
    chk("midreset outs", act, 0); chk("midreset state", st, 0);

    dut2_illegal("nojal jal", 6'b000011, 6'h00);
    dut2_illegal("nojal jr",  6'b000000, 6'b001000);
    dut2_illegal("nobne bne", 6'b000101, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
